// File: rtl/servo_pkg.sv
// Shared constants, scheduler state type and the pulse-width clamp used by the servo path.
package servo_pkg;

  localparam int unsigned CLK_FREQ_HZ = 25_000_000;
  localparam int unsigned FRAME_US    = 20000;
  localparam int unsigned MIN_US      = 500;
  localparam int unsigned MAX_US      = 2500;
  localparam int unsigned CENTER_US   = 1500;

  typedef enum logic [1:0] {
    StLoad,
    StPulse,
    StGap
  } sched_state_e;

  function automatic logic [15:0] clamp_us(input logic [15:0] us,
                                           input logic [15:0] lo,
                                           input logic [15:0] hi);
    if (us < lo) return lo;
    if (us > hi) return hi;
    return us;
  endfunction

endpackage

// File: rtl/servo_frame_scheduler_if.sv
// Pulse-width command write port: valid/ready handshake plus the clamp indication.
interface servo_frame_scheduler_if #(
  parameter int unsigned SEL_W = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_sel;
  logic [15:0]      cmd_us;
  logic             cmd_clamped;

  modport master (output cmd_valid, cmd_sel, cmd_us, input cmd_ready, cmd_clamped);
  modport slave  (input cmd_valid, cmd_sel, cmd_us, output cmd_ready, cmd_clamped);
endinterface

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: tick on the terminal count, pre-tick one cycle before it.
module us_tick_gen #(
  parameter int unsigned TICKS_PER_US = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic us_tick_o,
  output logic pre_tick_o
);
  localparam int unsigned PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  logic [PW-1:0] presc_q, presc_d;

  assign us_tick_o = (presc_q == PW'(TICKS_PER_US - 1));

  // With one tick per cycle every cycle precedes a tick.
  if (TICKS_PER_US == 1) begin : g_pre_one
    assign pre_tick_o = 1'b1;
  end else begin : g_pre_cnt
    assign pre_tick_o = (presc_q == PW'(TICKS_PER_US - 2));
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (clr_i || us_tick_o) presc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

endmodule

// File: rtl/servo_frame_scheduler.sv
// Slot-based servo PWM scheduler: one shared us timebase, one pulse per slot per frame,
// commands staged in pending registers and copied to shadow registers at each frame start.
module servo_frame_scheduler #(
  parameter int unsigned CLK_FREQ_HZ = servo_pkg::CLK_FREQ_HZ,
  parameter int unsigned NUM_SERVOS  = 4,
  parameter int unsigned FRAME_US    = servo_pkg::FRAME_US,
  parameter int unsigned SLOT_US     = FRAME_US / NUM_SERVOS,
  parameter int unsigned MIN_US      = servo_pkg::MIN_US,
  parameter int unsigned MAX_US      = servo_pkg::MAX_US,
  parameter int unsigned CENTER_US   = servo_pkg::CENTER_US
) (
  input  logic                          clk,
  input  logic                          rst_n,
  servo_frame_scheduler_if.slave        cmd_if,
  output logic                          frame_start,
  output logic [$clog2(NUM_SERVOS)-1:0] active_slot,
  output logic [NUM_SERVOS-1:0]         servo_pwm
);
  import servo_pkg::*;

  localparam int unsigned TICKS_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned SelW         = $clog2(NUM_SERVOS);
  localparam logic [15:0] MinUs        = 16'(MIN_US);
  localparam logic [15:0] MaxUs        = 16'(MAX_US);
  localparam logic [15:0] CenterUs     = 16'(CENTER_US);
  localparam logic [15:0] SlotUs       = 16'(SLOT_US);
  // LOAD replaces the final cycle of the frame, so leave the last slot one cycle early.
  localparam logic [15:0] LastUs       = (TICKS_PER_US == 1) ? 16'(SLOT_US - 2) :
                                                               16'(SLOT_US - 1);
  localparam logic [SelW-1:0] LastSlot = SelW'(NUM_SERVOS - 1);

  sched_state_e         state_q, state_d;
  logic [15:0]          us_cnt_q, us_cnt_d;
  logic [SelW-1:0]      slot_q, slot_d;
  logic [15:0]          pending_q [NUM_SERVOS];
  logic [15:0]          pending_d [NUM_SERVOS];
  logic [15:0]          shadow_q  [NUM_SERVOS];
  logic [15:0]          shadow_d  [NUM_SERVOS];
  logic                 frame_start_q, frame_start_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 cmd_clamped_q, cmd_clamped_d;
  logic [NUM_SERVOS-1:0] pwm_q, pwm_d;
  logic                 presc_clr, us_tick, pre_tick;

  us_tick_gen #(
    .TICKS_PER_US(TICKS_PER_US)
  ) u_us_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (presc_clr),
    .us_tick_o (us_tick),
    .pre_tick_o(pre_tick)
  );

  always_comb begin
    state_d   = state_q;
    us_cnt_d  = us_cnt_q;
    slot_d    = slot_q;
    shadow_d  = shadow_q;
    presc_clr = 1'b0;
    unique case (state_q)
      StLoad: begin
        presc_clr = 1'b1;
        us_cnt_d  = '0;
        slot_d    = '0;
        // Straight out of reset LOAD is held one extra cycle so it is flagged by frame_start.
        if (frame_start_q) begin
          shadow_d = pending_q;
          state_d  = StPulse;
        end
      end
      StPulse: begin
        if (us_tick) begin
          us_cnt_d = us_cnt_q + 16'd1;
          if (us_cnt_d == shadow_q[slot_q]) state_d = StGap;
        end
      end
      StGap: begin
        if (slot_q == LastSlot && us_cnt_q == LastUs && pre_tick) begin
          state_d  = StLoad;
          us_cnt_d = '0;
          slot_d   = '0;
        end else if (us_tick) begin
          if (us_cnt_q + 16'd1 == SlotUs) begin
            us_cnt_d = '0;
            slot_d   = slot_q + SelW'(1);
            state_d  = StPulse;
          end else begin
            us_cnt_d = us_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    pending_d     = pending_q;
    cmd_clamped_d = 1'b0;
    if (cmd_if.cmd_valid && cmd_ready_q && (32'(cmd_if.cmd_sel) < NUM_SERVOS)) begin
      pending_d[cmd_if.cmd_sel] = clamp_us(cmd_if.cmd_us, MinUs, MaxUs);
      cmd_clamped_d = (cmd_if.cmd_us < MinUs) || (cmd_if.cmd_us > MaxUs);
    end
  end

  always_comb begin
    frame_start_d = (state_d == StLoad);
    cmd_ready_d   = (state_d != StLoad);
    for (int k = 0; k < NUM_SERVOS; k++) begin
      pwm_d[k] = (state_d == StPulse) && (slot_d == SelW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StLoad;
      us_cnt_q      <= '0;
      slot_q        <= '0;
      pending_q     <= '{default: CenterUs};
      shadow_q      <= '{default: CenterUs};
      frame_start_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      cmd_clamped_q <= 1'b0;
      pwm_q         <= '0;
    end else begin
      state_q       <= state_d;
      us_cnt_q      <= us_cnt_d;
      slot_q        <= slot_d;
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      frame_start_q <= frame_start_d;
      cmd_ready_q   <= cmd_ready_d;
      cmd_clamped_q <= cmd_clamped_d;
      pwm_q         <= pwm_d;
    end
  end

  assign cmd_if.cmd_ready   = cmd_ready_q;
  assign cmd_if.cmd_clamped = cmd_clamped_q;
  assign frame_start        = frame_start_q;
  assign active_slot        = slot_q;
  assign servo_pwm          = pwm_q;

endmodule

// File: doc/servo_frame_scheduler.md
# servo_frame_scheduler

Time-slot scheduler that drives all servo PWM outputs of the robot arm from one shared microsecond timebase and one pulse comparator. The 20 ms servo frame is split into equal slots, one per servo. Each servo pulses only inside its own slot, which staggers the inrush current of the servos. Pulse-width commands arrive over a valid/ready write port from the joystick-mapping and servo-selection logic. They are clamped, held in pending registers, and applied atomically at the next frame boundary, so a pulse is never cut short or stretched mid-frame.

## Interface
- CLK_FREQ_HZ, 25_000_000: CLK frequency. TICKS_PER_US = CLK_FREQ_HZ/1_000_000, which must be an integer.
- NUM_SERVOS, 4: number of servo outputs/slots.
- FRAME_US, 20000: frame period in µs.
- SLOT_US, FRAME_US/NUM_SERVOS: slot length in µs. Must be greater than MAX_US.
- MIN_US, 500 / MAX_US, 2500 / CENTER_US, 1500: clamp limits and the reset pulse width.
- CLK  in  1  system clock.
- RST_N  in  1  reset. Asynchronous, active-low.
- cmd_valid  in  1  write request.
- cmd_ready  out  1  write accepted when cmd_valid && cmd_ready.
- cmd_sel  in  $clog2(NUM_SERVOS)  target servo index.
- cmd_us  in  16  requested pulse width in µs, unsigned.
- cmd_clamped  out  1  one-cycle pulse when an accepted cmd_us was clamped.
- frame_start  out  1  one-cycle pulse in the LOAD cycle.
- active_slot  out  $clog2(NUM_SERVOS)  index of the slot currently running.
- servo_pwm  out  NUM_SERVOS  PWM outputs, bit k drives servo k.

## Operation
- **Reset values:** all pending[k] and shadow[k] = CENTER_US. servo_pwm = 0, cmd_ready = 0, cmd_clamped = 0, frame_start = 0, active_slot = 0. The prescaler and µs counter are 0. State = LOAD.
- **Prescaler:** counts 0..TICKS_PER_US-1. us_tick is asserted on the terminal count.
- **LOAD** (1 cycle):
  - shadow[k] <= pending[k] for all k.
  - frame_start = 1, cmd_ready = 0.
  - slot = 0, us_cnt = 0, prescaler = 0.
  - Next state: PULSE.
- **PULSE:**
  - servo_pwm[slot] = 1. All other bits = 0.
  - us_cnt increments on us_tick.
  - When us_cnt reaches shadow[slot] on a tick, go to GAP.
- **GAP:**
  - All servo_pwm = 0. us_cnt keeps counting.
  - When us_cnt reaches SLOT_US on a tick: us_cnt = 0 and slot++.
  - If slot was NUM_SERVOS-1, go to LOAD instead. The LOAD cycle takes the place of the first cycle of the next frame, so the frame period is exact.
- **Write port:**
  - cmd_ready = 1 in PULSE and GAP, 0 in LOAD and during reset.
  - On an accepted write: pending[cmd_sel] <= clamp(cmd_us, MIN_US, MAX_US).
  - cmd_clamped pulses the next cycle if cmd_us < MIN_US or cmd_us > MAX_US.
  - A cmd_sel >= NUM_SERVOS is accepted and discarded, with no clamp pulse.
- **Multiple writes:** several writes to the same servo within one frame resolve last-wins. Writes to different servos are independent.
- **Arithmetic:**
  - us_cnt is 16-bit unsigned.
  - The clamp compares the full 16 bits, so cmd_us = 0 becomes MIN_US and 16'hFFFF becomes MAX_US. No signed arithmetic.

## Timing
- All outputs are registered. servo_pwm is glitch-free.
- Frame period = FRAME_US*TICKS_PER_US cycles (500000 at the defaults).
- Slot k rises at frame_start cycle + 1 + k*SLOT_US*TICKS_PER_US cycles.
- servo_pwm[k] is high for exactly shadow[k]*TICKS_PER_US cycles.
- **Write latency:** a write accepted in frame n takes effect in frame n+1.
- **Write during LOAD:** a write presented in the LOAD cycle stalls one cycle, is accepted in the next cycle, and takes effect one frame later.
- **First frame:** LOAD occurs in the first clock after RST_N deasserts, so the first frame uses CENTER_US on every servo.
- **Reset mid-operation:** RST_N low forces servo_pwm to 0 immediately (asynchronous) and discards pending commands. On release, the block restarts with a fresh frame.

## Structure
- Shared package servo_pkg holds:
  - CLK_FREQ_HZ, MIN_US, MAX_US, CENTER_US, FRAME_US.
  - The scheduler state enum {LOAD, PULSE, GAP}.
- One sub-module, us_tick_gen: the prescaler producing us_tick. It resets to 0 and has a synchronous clear used by LOAD.
- The clamp is a package function shared with the joystick-mapping logic.

## Test plan
- **Reset and idle:** release RST_N with no writes.
  - frame_start every 500000 cycles.
  - Each servo_pwm[k] high for 37500 cycles (1500 µs), starting 125000*k + 1 cycles after frame_start.
- **Normal write:** write servo 2 = 1000 mid-frame.
  - The current frame keeps 37500 cycles.
  - The next frame gives servo_pwm[2] high for 25000 cycles. Other servos are unchanged.
- **Clamping:**
  - Write servo 0 = 0: cmd_clamped pulses, and the next frame pulse is 12500 cycles (500 µs).
  - Write servo 0 = 9000: cmd_clamped pulses, and the pulse is 62500 cycles (2500 µs).
- **Write during LOAD:** hold cmd_valid across the frame_start cycle.
  - cmd_ready is low for exactly that cycle.
  - The write is accepted the next cycle and applied one frame later.
- **Last-wins:** in one frame write servo 3 = 1200, then 1800.
  - Only 1800 (45000 cycles) appears in the next frame.
- **Reset mid-pulse:** assert RST_N during servo 1's pulse.
  - servo_pwm drops to 0 with no clock.
  - After release, all servos return to 1500 µs, and the earlier pending writes are lost.
